// File: rtl/convn_valid_mul_arb_pkg.sv
// Shared types, widths and helpers for the convn_valid multiplier arbiter.
package convn_valid_mul_arb_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned DIN_W_DEF = 31;
  localparam int unsigned MUL_LAT   = 1;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EMPTY = 2'd2
  } arb_state_e;

  // Product width of two unsigned operands.
  function automatic int unsigned dout_width(input int unsigned din_w);
    return 2 * din_w;
  endfunction

  // Requester ID width, never below one bit.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  // Round-robin pointer successor: (idx + 1) mod nreq.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/convn_valid_mul_31ns_31ns_62_2_1.sv
// Unsigned pipelined multiplier: operands zero-extended, signed multiply,
// NUM_STAGE-1 ce-qualified register stages, full-width product.
module convn_valid_mul_31ns_31ns_62_2_1 #(
  parameter int unsigned NUM_STAGE = 2,
  parameter int unsigned DIN0_W    = 31,
  parameter int unsigned DIN1_W    = 31,
  parameter int unsigned DOUT_W    = 62
) (
  input  logic              clk,
  input  logic              ce,
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  output logic [DOUT_W-1:0] dout
);

  logic signed [DIN0_W:0]   a_ext;
  logic signed [DIN1_W:0]   b_ext;
  logic signed [DOUT_W-1:0] prod_c;
  logic        [DOUT_W-1:0] stage [NUM_STAGE-1];

  assign a_ext  = {1'b0, din0};
  assign b_ext  = {1'b0, din1};
  assign prod_c = DOUT_W'(a_ext) * DOUT_W'(b_ext);

  // Product pipeline; frozen whenever ce is low.
  always_ff @(posedge clk) begin
    if (ce) begin
      stage[0] <= prod_c;
      for (int s = 1; s < NUM_STAGE - 1; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign dout = stage[NUM_STAGE-2];

endmodule

// File: rtl/convn_valid_mul_arb.sv
// Round-robin arbiter/sequencer sharing one pipelined 31x31 multiplier among
// NREQ requesters, with ID tagging, response backpressure and a drain mode.
// Optional statistics counters: define CONVN_MUL_ARB_STATS_EN.
module convn_valid_mul_arb
  import convn_valid_mul_arb_pkg::*;
#(
  parameter  int unsigned NREQ   = NREQ_DEF,
  parameter  int unsigned DIN_W  = DIN_W_DEF,
  localparam int unsigned DOUT_W = dout_width(DIN_W),
  localparam int unsigned ID_W   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DIN_W-1:0] req_din0,
  input  logic [NREQ*DIN_W-1:0] req_din1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DOUT_W-1:0]     rsp_data,
  input  logic                  drain,
`ifdef CONVN_MUL_ARB_STATS_EN
  output logic [NREQ*STAT_W-1:0] stat_issue,
  output logic [STAT_W-1:0]      stat_stall,
`endif
  output logic                  idle
);

  logic              ce;
  arb_state_e        state;
  arb_state_e        state_next;
  logic              run_grant;
  logic              grant_en;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  int unsigned       cand;
  logic              xfer;
  logic [ID_W-1:0]   ptr;
  logic [DIN_W-1:0]  mul_a;
  logic [DIN_W-1:0]  mul_b;
  logic [DOUT_W-1:0] mul_dout;
  logic              tag_valid [MUL_LAT];
  logic [ID_W-1:0]   tag_id    [MUL_LAT];
  logic              pipe_busy;

  // Pipeline advances unless a held response is not being taken.
  assign ce = ~(rsp_valid & ~rsp_ready);

  // Any tagged product still inside the multiplier.
  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned s = 0; s < MUL_LAT; s++) begin
      if (tag_valid[s]) pipe_busy = 1'b1;
    end
  end

  assign idle = ~pipe_busy & ~rsp_valid;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  // FSM next state; grants are allowed only in RUN.
  always_comb begin
    state_next = state;
    run_grant  = 1'b0;
    case (state)
      RUN: begin
        run_grant = 1'b1;
        if (drain) state_next = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy && !rsp_valid) state_next = EMPTY;
      end
      EMPTY: begin
        if (!drain) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign grant_en = ce & run_grant & reset_n;

  // Round-robin search over req_valid starting at the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gnt_found && req_valid[ID_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  assign xfer = gnt_found & grant_en;

  // One-hot accept and operand mux for the granted requester.
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        req_ready[i] = xfer;
        mul_a        = req_din0[i*DIN_W +: DIN_W];
        mul_b        = req_din1[i*DIN_W +: DIN_W];
      end
    end
  end

  // Pointer moves past the requester just served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ptr <= '0;
    else if (xfer) ptr <= ID_W'(rr_next(32'(gnt_idx), NREQ));
  end

  // Tag pipeline tracking ownership alongside the multiplier stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < MUL_LAT; s++) begin
        tag_valid[s] <= 1'b0;
        tag_id[s]    <= '0;
      end
    end else if (ce) begin
      tag_valid[0] <= xfer;
      tag_id[0]    <= gnt_idx;
      for (int unsigned s = 1; s < MUL_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  // Response capture stage; holds while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (ce) begin
      rsp_valid <= tag_valid[MUL_LAT-1];
      rsp_id    <= tag_id[MUL_LAT-1];
      rsp_data  <= mul_dout;
    end
  end

  convn_valid_mul_31ns_31ns_62_2_1 #(
    .NUM_STAGE (MUL_LAT + 1),
    .DIN0_W    (DIN_W),
    .DIN1_W    (DIN_W),
    .DOUT_W    (DOUT_W)
  ) u_mul (
    .clk  (clk),
    .ce   (ce),
    .din0 (mul_a),
    .din1 (mul_b),
    .dout (mul_dout)
  );

`ifdef CONVN_MUL_ARB_STATS_EN
  logic [STAT_W-1:0] issue_cnt [NREQ];
  logic [STAT_W-1:0] stall_cnt;

  // Saturating per-requester transfer counters and stall-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREQ; i++) issue_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && issue_cnt[i] != '1) begin
          issue_cnt[i] <= issue_cnt[i] + STAT_W'(1);
        end
      end
      if (!ce && stall_cnt != '1) stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_issue[g*STAT_W +: STAT_W] = issue_cnt[g];
  end
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_convn_valid_mul_arb.sv
// Directed bench for convn_valid_mul_arb: single issue, round-robin stream,
// max operands, backpressure, drain and mid-stream reset.
module tb_convn_valid_mul_arb;
  import convn_valid_mul_arb_pkg::*;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DIN_W  = 31;
  localparam int unsigned DOUT_W = 62;
  localparam int unsigned ID_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DIN_W-1:0] din0;
  logic [NREQ*DIN_W-1:0] din1;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [DOUT_W-1:0]     rsp_data;
  logic                  drain;
  logic                  idle;
`ifdef CONVN_MUL_ARB_STATS_EN
  logic [NREQ*16-1:0]    stat_issue;
  logic [15:0]           stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  gnt_order [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [1:0]  id_order  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [63:0] exp_prod  [4] = '{64'd20, 64'd33, 64'd48, 64'd65};

  convn_valid_mul_arb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (din0),
    .req_din1  (din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .drain     (drain),
`ifdef CONVN_MUL_ARB_STATS_EN
    .stat_issue(stat_issue),
    .stat_stall(stat_stall),
`endif
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [DIN_W-1:0] a, input logic [DIN_W-1:0] b);
    din0[i*DIN_W +: DIN_W] = a;
    din1[i*DIN_W +: DIN_W] = b;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [63:0] data);
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_id"},    64'(rsp_id),    64'(id));
    check({tag, "_data"},  64'(rsp_data),  data);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    drain     = 1'b0;
    din0      = '0;
    din1      = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_idle",      64'(idle),      64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single request: 3*5 on requester 0, two cycles latency
    @(negedge clk);
    set_ops(0, 31'd3, 31'd5);
    req_valid = 4'b0001;
    #1;
    check("single_gnt", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_early_valid", 64'(rsp_valid), 64'd0);
    check("single_busy", 64'(idle), 64'd0);
    @(negedge clk);
    #1;
    check_rsp("single_rsp", 2'd0, 64'd15);
    @(negedge clk);
    #1;
    check("single_done_valid", 64'(rsp_valid), 64'd0);
    check("single_idle", 64'(idle), 64'd1);

    // Continuous stream from all requesters; pointer starts at 1
    for (int i = 0; i < 4; i++) set_ops(i, DIN_W'(i + 2), DIN_W'(i + 10));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      if (c < 5) check($sformatf("stream_gnt%0d", c), 64'(req_ready), 64'(gnt_order[c]));
      if (c >= 2 && c < 7) check_rsp($sformatf("stream_rsp%0d", c - 2), id_order[c-2], exp_prod[id_order[c-2]]);
      else check($sformatf("stream_none%0d", c), 64'(rsp_valid), 64'd0);
    end

    // Max operands on requester 2 (pointer at 2)
    @(negedge clk);
    set_ops(2, 31'h7FFF_FFFF, 31'h7FFF_FFFF);
    req_valid = 4'b0100;
    #1;
    check("max_gnt", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check_rsp("max_rsp", 2'd2, 64'h3FFF_FFFF_0000_0001);
    set_ops(2, 31'd4, 31'd12);

    // Backpressure: rsp_ready low for 5 cycles (pointer at 3)
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("bp_gnt0", 64'(req_ready), 64'b1000);
    @(negedge clk);
    #1;
    check("bp_gnt1", 64'(req_ready), 64'b0001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check($sformatf("bp_block%0d", c), 64'(req_ready), 64'd0);
      check_rsp($sformatf("bp_hold%0d", c), 2'd3, 64'd65);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_gnt2", 64'(req_ready), 64'b0010);
    check_rsp("bp_rsp3", 2'd3, 64'd65);
    @(negedge clk);
    req_valid = '0;
    #1;
    check_rsp("bp_rsp0", 2'd0, 64'd20);
    @(negedge clk);
    #1;
    check_rsp("bp_rsp1", 2'd1, 64'd33);
    @(negedge clk);
    #1;
    check("bp_end_valid", 64'(rsp_valid), 64'd0);
`ifdef CONVN_MUL_ARB_STATS_EN
    check("stat_stall", 64'(stat_stall), 64'd5);
    check("stat_issue0", 64'(stat_issue[15:0]),  64'd3);
    check("stat_issue1", 64'(stat_issue[31:16]), 64'd3);
    check("stat_issue2", 64'(stat_issue[47:32]), 64'd2);
    check("stat_issue3", 64'(stat_issue[63:48]), 64'd2);
`endif

    // Drain with two products in flight (pointer at 2)
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("drain_gnt0", 64'(req_ready), 64'b0100);
    @(negedge clk);
    drain = 1'b1;
    #1;
    check("drain_same_cycle_gnt", 64'(req_ready), 64'b1000);
    @(negedge clk);
    #1;
    check("drain_block0", 64'(req_ready), 64'd0);
    check_rsp("drain_rsp2", 2'd2, 64'd48);
    @(negedge clk);
    #1;
    check("drain_block1", 64'(req_ready), 64'd0);
    check_rsp("drain_rsp3", 2'd3, 64'd65);
    check("drain_busy", 64'(idle), 64'd0);
    @(negedge clk);
    #1;
    check("drain_empty_valid", 64'(rsp_valid), 64'd0);
    check("drain_idle", 64'(idle), 64'd1);
    @(negedge clk);
    #1;
    check("drain_fsm_empty", 64'(dut.state), 64'(EMPTY));
    check("drain_empty_block", 64'(req_ready), 64'd0);
    check("drain_empty_idle", 64'(idle), 64'd1);
    @(negedge clk);
    drain = 1'b0;
    #1;
    check("drain_release_block", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    check("drain_resume_gnt", 64'(req_ready), 64'b0001);

    // Reset pulse mid-stream
    @(negedge clk);
    #1;
    check("rst_mid_gnt", 64'(req_ready), 64'b0010);
    @(negedge clk);
    #1;
    check_rsp("rst_mid_rsp", 2'd0, 64'd20);
    reset_n = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_mid_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_mid_req_ready", 64'(req_ready), 64'd0);
    check("rst_mid_idle",      64'(idle),      64'd1);
    @(negedge clk);
    req_valid = '0;
    reset_n   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_post_quiet%0d", c), 64'(rsp_valid), 64'd0);
    end
`ifdef CONVN_MUL_ARB_STATS_EN
    check("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif
    @(negedge clk);
    set_ops(0, 31'd3, 31'd5);
    req_valid = 4'b0001;
    #1;
    check("rst_post_gnt", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    check_rsp("rst_post_rsp", 2'd0, 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
